// File: rtl/rv_isa_pkg.sv
// RISC-V base-ISA opcode/funct3 constants and immediate format classes,
// shared by the immediate decode stage and the control unit.
package rv_isa_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FMT_W    = 3;

  localparam logic [OPCODE_W-1:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_OP        = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_OP_32     = 7'b0111011;
  localparam logic [OPCODE_W-1:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPCODE_JAL       = 7'b1101111;

  localparam logic [FUNCT3_W-1:0] FUNCT3_SLLI      = 3'b001;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SRLI_SRAI = 3'b101;

  typedef enum logic [FMT_W-1:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate generator: instruction word -> immediate, format
// class and illegal flag. Illegal encodings always yield imm=0, FMT_NONE.
module imm_extract
  import rv_isa_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          SHIFT_BJ = 1'b0
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm_c,
  output fmt_e            fmt_c,
  output logic            illegal_c
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT3_W-1:0] funct3;
  logic                is_shift;
  logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j, shamt5, shamt6;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign is_shift = (funct3 == FUNCT3_SLLI) || (funct3 == FUNCT3_SRLI_SRAI);

  // Sign extension always comes from ir[31]; shamts are zero-extended.
  assign imm_i  = XLEN'($signed(ir[31:20]));
  assign imm_s  = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_b  = SHIFT_BJ ? XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}))
                           : XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8]}));
  assign imm_j  = SHIFT_BJ ? XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}))
                           : XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21]}));
  assign imm_u  = XLEN'($signed({ir[31:12], 12'b0}));
  assign shamt5 = XLEN'(ir[24:20]);
  assign shamt6 = XLEN'(ir[25:20]);

  always_comb begin
    imm_c     = '0;
    fmt_c     = FMT_NONE;
    illegal_c = 1'b0;
    if (ir[1:0] != 2'b11) begin
      illegal_c = 1'b1;
    end else begin
      case (opcode)
        OPCODE_OP: fmt_c = FMT_R;
        OPCODE_OP_IMM: begin
          fmt_c = FMT_I;
          if (!is_shift) begin
            imm_c = imm_i;
          end else if (IS_RV64) begin
            imm_c = shamt6;
          end else begin
            imm_c     = shamt5;
            illegal_c = ir[25];
          end
        end
        OPCODE_OP_IMM_32: begin
          fmt_c     = FMT_I;
          imm_c     = is_shift ? shamt5 : imm_i;
          illegal_c = !IS_RV64;
        end
        OPCODE_OP_32: begin
          fmt_c     = FMT_R;
          illegal_c = !IS_RV64;
        end
        OPCODE_LOAD, OPCODE_JALR: begin
          fmt_c = FMT_I;
          imm_c = imm_i;
        end
        OPCODE_STORE: begin
          fmt_c = FMT_S;
          imm_c = imm_s;
        end
        OPCODE_BRANCH: begin
          fmt_c = FMT_B;
          imm_c = imm_b;
        end
        OPCODE_JAL: begin
          fmt_c = FMT_J;
          imm_c = imm_j;
        end
        OPCODE_LUI, OPCODE_AUIPC: begin
          fmt_c = FMT_U;
          imm_c = imm_u;
        end
        default: illegal_c = 1'b1;
      endcase
    end
    if (illegal_c) begin
      imm_c = '0;
      fmt_c = FMT_NONE;
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered, valid/ready immediate-decode stage with a 2-entry skid buffer
// (output register + skid register) for full throughput under backpressure.
module imm_decode_stage
  import rv_isa_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          SHIFT_BJ = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } beat_t;

  localparam beat_t BEAT_RST = '{ir: '0, pc: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};

  beat_t           out_q, out_d, skid_q, skid_d, dec_beat;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, drain;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_extract #(
    .XLEN     (XLEN),
    .SHIFT_BJ (SHIFT_BJ)
  ) u_imm_extract (
    .ir        (in_ir),
    .imm_c     (dec_imm),
    .fmt_c     (dec_fmt),
    .illegal_c (dec_illegal)
  );

  assign dec_beat = '{ir: in_ir, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = ~out_valid_q | out_ready;

  // Skid drains into the output register before any new word; in_ready is low
  // whenever skid is full, so the two never compete.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec_beat;
      end
    end else if (accept) begin
      skid_d       = dec_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= BEAT_RST;
      skid_q       <= BEAT_RST;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ir      = out_q.ir;
  assign out_pc      = out_q.pc;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

endmodule
